// File: rtl/serial_byte_collector.sv
// Assembles framed serial bits (8 data bits plus optional parity) into a byte.
// A single-cycle load strobe is issued only for clean frames.
module serial_byte_collector #(
  parameter string BIT_ORDER = "MSB",
  parameter string PARITY    = "NONE"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       sin,
  input  logic       sin_valid,
  output logic       load,
  output logic [7:0] load_value,
  output logic       busy,
  output logic       parity_err
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR} state_e;

  localparam bit MSB_FIRST = (BIT_ORDER != "LSB");
  localparam bit HAS_PAR   = (PARITY != "NONE");
  localparam bit ODD_PAR   = (PARITY == "ODD");

  state_e      state_q;
  logic [7:0]  sreg_q, sreg_d;
  logic [2:0]  cnt_q;
  logic        load_q, busy_q, perr_q;
  logic [7:0]  lv_q;
  logic        par_x, par_ok;

  assign sreg_d = MSB_FIRST ? {sreg_q[6:0], sin} : {sin, sreg_q[7:1]};
  assign par_x  = ^{sreg_q, sin};
  assign par_ok = ODD_PAR ? par_x : ~par_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      lv_q    <= '0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      perr_q <= 1'b0;
      // frame_start takes priority in every state, including the final-bit edge
      if (frame_start) begin
        state_q <= S_DATA;
        sreg_q  <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          S_DATA: if (sin_valid) begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (HAS_PAR) begin
                state_q <= S_PAR;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                load_q  <= 1'b1;
                lv_q    <= sreg_d;
              end
            end
          end
          S_PAR: if (sin_valid) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            if (par_ok) begin
              load_q <= 1'b1;
              lv_q   <= sreg_q;
            end else begin
              perr_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign load       = load_q;
  assign load_value = lv_q;
  assign busy       = busy_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_serial_byte_collector.sv
// Directed bench: three collector flavours (MSB/NONE, LSB/NONE, MSB/EVEN)
// share one stimulus stream; expected values are hand-computed constants.
module tb_serial_byte_collector;

  logic clk = 1'b0;
  logic rst, fs, sin, sv;
  logic       m_ld, l_ld, e_ld, m_bz, l_bz, e_bz, m_pe, l_pe, e_pe;
  logic [7:0] m_lv, l_lv, e_lv;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_byte_collector #(.BIT_ORDER("MSB"), .PARITY("NONE")) u_m (
    .clk(clk), .rst(rst), .frame_start(fs), .sin(sin), .sin_valid(sv),
    .load(m_ld), .load_value(m_lv), .busy(m_bz), .parity_err(m_pe));
  serial_byte_collector #(.BIT_ORDER("LSB"), .PARITY("NONE")) u_l (
    .clk(clk), .rst(rst), .frame_start(fs), .sin(sin), .sin_valid(sv),
    .load(l_ld), .load_value(l_lv), .busy(l_bz), .parity_err(l_pe));
  serial_byte_collector #(.BIT_ORDER("MSB"), .PARITY("EVEN")) u_e (
    .clk(clk), .rst(rst), .frame_start(fs), .sin(sin), .sin_valid(sv),
    .load(e_ld), .load_value(e_lv), .busy(e_bz), .parity_err(e_pe));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive on the falling edge, advance one rising edge, settle 1 time unit
  task automatic cyc(input logic r, input logic f, input logic v, input logic s);
    @(negedge clk);
    rst = r; fs = f; sv = v; sin = s;
    @(posedge clk);
    #1;
  endtask

  // 8 bits, first-sent = b[7]; optional idle cycle between bits
  task automatic send8(input logic [7:0] b, input bit stall, input string tag);
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b0, 1'b0, 1'b1, b[i]);
      if (i != 0) begin
        chk({tag, "_mid_ld"}, {7'd0, m_ld}, 8'd0);
        chk({tag, "_mid_bz"}, {7'd0, m_bz}, 8'd1);
      end
      if (stall && i != 0) cyc(1'b0, 1'b0, 1'b0, ~b[i]);
    end
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; sin = 1'b0; sv = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_ld", {7'd0, m_ld}, 8'd0);
    chk("rst_lv", m_lv, 8'h00);
    chk("rst_bz", {5'd0, m_bz, l_bz, e_bz}, 8'd0);
    chk("rst_pe", {5'd0, m_pe, l_pe, e_pe}, 8'd0);

    // A5: MSB and LSB both yield A5 (palindromic bit pattern)
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("a5_bz0", {5'd0, m_bz, l_bz, e_bz}, 8'h07);
    send8(8'hA5, 1'b0, "a5");
    chk("a5_m_ld", {7'd0, m_ld}, 8'd1);
    chk("a5_m_lv", m_lv, 8'hA5);
    chk("a5_l_lv", l_lv, 8'hA5);
    chk("a5_m_bz", {7'd0, m_bz}, 8'd0);
    chk("a5_e_st", {6'd0, e_ld, e_bz}, 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5_ld_1cyc", {6'd0, m_ld, l_ld}, 8'd0);
    chk("a5_hold", m_lv, 8'hA5);

    // 1,1,0,0,0,0,0,0 -> LSB 03, MSB C0
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    send8(8'hC0, 1'b0, "c0");
    chk("c0_l_lv", l_lv, 8'h03);
    chk("c0_m_lv", m_lv, 8'hC0);
    chk("c0_l_ld", {7'd0, l_ld}, 8'd1);

    // even parity with alternate-cycle stalls, good parity
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    send8(8'h3C, 1'b1, "3c");
    chk("3c_e_wait", {6'd0, e_ld, e_bz}, 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("3c_e_stall", {6'd0, e_ld, e_bz}, 8'h01);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("3c_e_ld", {6'd0, e_ld, e_pe}, 8'h02);
    chk("3c_e_lv", e_lv, 8'h3C);
    chk("3c_e_bz", {7'd0, e_bz}, 8'd0);

    // bad parity: dropped, load_value retained
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    send8(8'h3C, 1'b1, "3cb");
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("3cb_e_pe", {6'd0, e_ld, e_pe}, 8'h01);
    chk("3cb_e_lv", e_lv, 8'h3C);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("3cb_pe_1cyc", {7'd0, e_pe}, 8'd0);

    // restart after 4 bits, then F0
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, i[0]);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rs_no_ld", {6'd0, m_ld, e_ld}, 8'd0);
    send8(8'hF0, 1'b0, "f0");
    chk("f0_m_ld", {7'd0, m_ld}, 8'd1);
    chk("f0_m_lv", m_lv, 8'hF0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("f0_e_ld", {6'd0, e_ld, e_pe}, 8'h02);
    chk("f0_e_lv", e_lv, 8'hF0);

    // reset mid-frame after a completed 5A
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    send8(8'h5A, 1'b0, "5a");
    chk("5a_m_lv", m_lv, 8'h5A);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("mr_lv", m_lv | l_lv | e_lv, 8'h00);
    chk("mr_flags", {2'd0, m_ld, l_ld, e_ld, m_bz, l_bz, e_bz}, 8'd0);
    chk("mr_pe", {5'd0, m_pe, l_pe, e_pe}, 8'd0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("mr_ign_st", {2'd0, m_ld, l_ld, e_ld, m_bz, l_bz, e_bz}, 8'd0);
    chk("mr_ign_lv", m_lv, 8'h00);

    // frame_start collides with bit 8
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("col_ld", {6'd0, m_ld, l_ld}, 8'd0);
    chk("col_bz", {7'd0, m_bz}, 8'd1);
    send8(8'h96, 1'b0, "96");
    chk("96_m_ld", {7'd0, m_ld}, 8'd1);
    chk("96_m_lv", m_lv, 8'h96);
    chk("96_l_lv", l_lv, 8'h69);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_byte_collector.md
# serial_byte_collector

Serial-in, parallel-out front end that assembles framed serial bits into bytes and hands each completed byte to the downstream 8-bit shift register stage through its `load` / `load_value` inputs. Each frame carries 8 data bits, optionally followed by one parity bit. The block validates parity and issues a single-cycle load pulse only for clean frames. It sits directly upstream of the shift-register stage on the same clock.

## Interface
Parameters:
- `BIT_ORDER`, default "MSB": "MSB" means the first received bit lands in `load_value[7]`; "LSB" means it lands in `load_value[0]`.
- `PARITY`, default "NONE": "NONE", "EVEN" or "ODD"; selects whether a parity bit follows the 8 data bits.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `frame_start`  input  1  begins a new frame; sampled every cycle
- `sin`  input  1  serial data bit
- `sin_valid`  input  1  `sin` holds a valid bit this cycle
- `load`  output  1  registered one-cycle strobe; a byte is ready
- `load_value`  output  8  registered assembled byte; held between strobes
- `busy`  output  1  registered; high while a frame is in progress
- `parity_err`  output  1  registered one-cycle strobe; a frame was dropped on parity mismatch

## Operation
- **State machine:** IDLE, DATA, PAR.
- **Internal state:** 8-bit shift register `sreg` and 3-bit bit counter `cnt`.
- **IDLE**
  - `sin_valid` is ignored.
  - `frame_start=1` moves to DATA and clears `sreg` and `cnt`.
  - `sin` is not sampled on the `frame_start` cycle.
- **DATA**, each cycle with `sin_valid=1`:
  - MSB order: `sreg <= {sreg[6:0], sin}`.
  - LSB order: `sreg <= {sin, sreg[7:1]}`.
  - `cnt` increments.
- **On the 8th accepted bit (`cnt==7`):**
  - PARITY="NONE": `load_value` takes the completed byte, `load=1`, go to IDLE.
  - Otherwise: go to PAR.
- **PAR**, on `sin_valid=1`:
  - Compute XOR of the 8 data bits and `sin`.
  - EVEN passes when the XOR is 0; ODD passes when it is 1.
  - Pass: `load_value <= sreg`, `load=1`.
  - Fail: `parity_err=1`; `load_value` is unchanged.
  - Either way, go to IDLE.
- **`frame_start=1` in DATA or PAR:** abort and restart. Clear `sreg` and `cnt`, stay in or enter DATA, discard the partial frame; no `load`, no `parity_err`.
- **`frame_start` on the same edge as the final data or parity bit:** `frame_start` wins. The byte is discarded, no strobe is issued, and a new frame begins.
- **`sin_valid=0` cycles:** stall the frame indefinitely; there is no timeout.
- **`busy`:** 1 in DATA and PAR, 0 in IDLE.
- **`load` and `parity_err`:** never high together, and never high for more than one cycle.

## Timing
- **Reset** (`rst=1` at a rising edge, priority over all inputs, in any state including mid-frame):
  - state=IDLE, `sreg=0`, `cnt=0`.
  - `load=0`, `load_value=8'h00`, `busy=0`, `parity_err=0`.
- **`busy`:** rises the cycle after the `frame_start` edge and falls the cycle after the final-bit edge.
- **`load` / `parity_err`:** high during the cycle immediately following the edge that sampled the final bit (data bit 8, or the parity bit).
- **`load_value`:** becomes valid with `load` and is stable until the next `load`.
- **Best-case throughput:**
  - NONE: 9 cycles per byte (1 start cycle + 8 bits).
  - EVEN/ODD: 10 cycles per byte.
  - Back-to-back is allowed: `frame_start` may assert in the same cycle `load` is high.
- **Downstream stage:** accepts `load` unconditionally, so no backpressure exists.

## Test plan
- **MSB order, PARITY=NONE:** `frame_start`, then bits 1,0,1,0,0,1,0,1 with `sin_valid=1`. Require `load_value=8'hA5` and `load=1` for exactly one cycle, the cycle after bit 8; `busy` high for 8 cycles.
- **LSB order, PARITY=NONE:** same bit stream. Require `load_value=8'hA5` (bit sequence mirrors to 8'hA5, palindrome). Repeat with 1,1,0,0,0,0,0,0 and require `load_value=8'h03`.
- **Stalls and even parity:**
  - PARITY="EVEN", MSB, byte 8'h3C with `sin_valid` low on alternate cycles, parity bit 0: require `load=1`, `load_value=8'h3C`.
  - Repeat with parity bit 1: require `parity_err=1`, `load=0`, `load_value` still 8'h3C.
- **Restart mid-frame:** `frame_start` after 4 bits, then full byte 8'hF0. Require a single `load` with 8'hF0 and no `parity_err`.
- **Reset mid-frame:** `rst` after 5 bits of a frame following a completed 8'h5A. Require all outputs 0 (`load_value=8'h00`) the next cycle; further `sin_valid` bits are ignored until `frame_start`.
- **Collision:** `frame_start` asserted on the same edge as bit 8. Require no `load`, `busy` stays 1, and the next 8 bits deliver a correct byte.
